// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the JTAG debug wrapper: synchronises tck-domain update strobes,
// queues DR snapshots in a FIFO and decodes popped commands into per-IR action pulses.
module jtag_debug_cmd_bridge #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACT_BIT     = 35
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      vs_udr,
  input  logic                      vs_uir,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [DATA_W-1:0]         sr,
  input  logic                      cmd_ready,
  input  logic                      ovf_clr,
  output logic                      cmd_valid,
  output logic [DATA_W-1:0]         jdo,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [(2**IR_W)-1:0]      take_action,
  output logic [(2**IR_W)-1:0]      take_no_action,
  output logic                      ir_update,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow
);

  localparam int unsigned NCH       = 2 ** IR_W;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;
  localparam int unsigned WARM_INIT = SYNC_STAGES + 1;
  localparam int unsigned WARM_W    = $clog2(SYNC_STAGES + 2);

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t                   mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_prev;
  logic                   uir_prev;
  logic [WARM_W-1:0]      warm_cnt;

  logic                   warm_done_c;
  logic                   udr_ev_c;
  logic                   uir_ev_c;
  logic                   full_c;
  logic                   pop_c;
  logic                   push_c;
  logic                   drop_c;
  logic [LVL_W-1:0]       level_nxt_c;
  logic [NCH-1:0]         sel_c;
  cmd_t                   head_c;

  // Event qualification, FIFO control and head presentation
  always_comb begin
    warm_done_c = (warm_cnt == '0);
    udr_ev_c    = warm_done_c && udr_sync[SYNC_STAGES-1] && !udr_prev;
    uir_ev_c    = warm_done_c && uir_sync[SYNC_STAGES-1] && !uir_prev;
    full_c      = (fifo_level == LVL_W'(DEPTH));
    pop_c       = cmd_valid && cmd_ready;
    push_c      = udr_ev_c && (!full_c || pop_c);
    drop_c      = udr_ev_c && full_c && !pop_c;
    head_c      = mem[rd_ptr];
    sel_c       = NCH'(1) << head_c.ir;
    level_nxt_c = fifo_level;
    if (push_c && !pop_c) begin
      level_nxt_c = fifo_level + LVL_W'(1);
    end else if (pop_c && !push_c) begin
      level_nxt_c = fifo_level - LVL_W'(1);
    end
    jdo    = cmd_valid ? head_c.data : '0;
    cmd_ir = cmd_valid ? head_c.ir   : '0;
  end

  // Strobe synchronisers, edge history and post-reset warm-up
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_prev <= 1'b0;
      uir_prev <= 1'b0;
      warm_cnt <= WARM_W'(WARM_INIT);
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_prev <= uir_sync[SYNC_STAGES-1];
      if (!warm_done_c) begin
        warm_cnt <= warm_cnt - WARM_W'(1);
      end
    end
  end

  // Storage is not reset; reads are masked while empty
  always_ff @(posedge clk) begin
    if (reset_n && push_c) begin
      mem[wr_ptr] <= '{ir: ir_in, data: sr};
    end
  end

  // Pointers, level, overflow and decoded pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      cmd_valid      <= 1'b0;
      overflow       <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= uir_ev_c;
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (head_c.data[ACT_BIT]) begin
          take_action <= sel_c;
        end else begin
          take_no_action <= sel_c;
        end
      end
      fifo_level <= level_nxt_c;
      cmd_valid  <= (level_nxt_c != '0);
      // A drop in the same cycle as a clear keeps the flag set
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
